// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures incoming hsync/vsync timing (line length, sync
// widths, lines per frame), flags saturated counters and reports lock once the
// measured frame geometry repeats for STABLE_FRAMES frames.
module vga_sync_monitor #(
    parameter int CNT_W         = 12,
    parameter int LINE_W        = 11,
    parameter bit H_POL         = 1'b0,
    parameter bit V_POL         = 1'b0,
    parameter int STABLE_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              clear,
    output logic [CNT_W-1:0]  h_total,
    output logic [CNT_W-1:0]  h_sync_len,
    output logic [LINE_W-1:0] v_total,
    output logic [LINE_W-1:0] v_sync_len,
    output logic              meas_valid,
    output logic              locked,
    output logic              frame_pulse,
    output logic              err_overflow
);

    localparam int                SW         = $clog2(STABLE_FRAMES + 1);
    localparam logic [SW-1:0]     STABLE_MAX = SW'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0]  H_SAT      = '1;
    localparam logic [LINE_W-1:0] L_SAT      = '1;

    typedef enum logic [1:0] {IDLE, ARM, VALID} state_t;

    state_t state, state_nxt;
    logic [SW-1:0] stable, stable_nxt;

    logic hs_p0, hs_p1, vs_p0, vs_p1;
    logic h_act_p2, h_act_p3, v_act_p2, v_act_p3;
    logic h_rise, h_fall, v_rise, v_fall;

    logic [CNT_W-1:0]  h_cnt, h_new, prev_h;
    logic [LINE_W-1:0] l_cnt, prev_v;
    logic h_full, l_full, ovf, pair_match;

    // Two-flop synchronizers, polarity normalization and the edge reference copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p0    <= ~H_POL;
            hs_p1    <= ~H_POL;
            vs_p0    <= ~V_POL;
            vs_p1    <= ~V_POL;
            h_act_p2 <= 1'b0;
            h_act_p3 <= 1'b0;
            v_act_p2 <= 1'b0;
            v_act_p3 <= 1'b0;
        end else begin
            hs_p0    <= hsync_in;
            hs_p1    <= hs_p0;
            vs_p0    <= vsync_in;
            vs_p1    <= vs_p0;
            h_act_p2 <= (hs_p1 == H_POL);
            h_act_p3 <= h_act_p2;
            v_act_p2 <= (vs_p1 == V_POL);
            v_act_p3 <= v_act_p2;
        end
    end

    assign h_rise = h_act_p2 & ~h_act_p3;
    assign h_fall = ~h_act_p2 & h_act_p3;
    assign v_rise = v_act_p2 & ~v_act_p3;
    assign v_fall = ~v_act_p2 & v_act_p3;

    // A counter that sits at all-ones and is not about to restart has overflowed
    assign h_full = (h_cnt == H_SAT);
    assign l_full = (l_cnt == L_SAT);
    assign ovf    = (h_full & ~h_rise) | (l_full & ~v_rise);

    // Line length seen by this frame edge: a coincident hsync edge refreshes it now
    assign h_new      = (h_rise && !h_full) ? h_cnt : h_total;
    assign pair_match = (h_new == prev_h) && (l_cnt == prev_v);

    // Counters and measured values; a saturated count never overwrites a measurement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt        <= '0;
            l_cnt        <= '0;
            h_total      <= '0;
            h_sync_len   <= '0;
            v_total      <= '0;
            v_sync_len   <= '0;
            frame_pulse  <= 1'b0;
            err_overflow <= 1'b0;
        end else if (clear) begin
            h_cnt        <= '0;
            l_cnt        <= '0;
            h_total      <= '0;
            h_sync_len   <= '0;
            v_total      <= '0;
            v_sync_len   <= '0;
            frame_pulse  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            frame_pulse <= v_rise;
            if (ovf)
                err_overflow <= 1'b1;

            if (h_rise) begin
                h_cnt <= CNT_W'(1);
                if (!h_full)
                    h_total <= h_cnt;
            end else if (!h_full) begin
                h_cnt <= h_cnt + 1'b1;
            end
            if (h_fall && !h_full)
                h_sync_len <= h_cnt;

            if (v_rise) begin
                l_cnt <= h_rise ? LINE_W'(1) : '0;
                if (state != IDLE && !l_full)
                    v_total <= l_cnt;
            end else if (h_rise && !l_full) begin
                l_cnt <= l_cnt + 1'b1;
            end
            if (v_fall && !l_full)
                v_sync_len <= l_cnt;
        end
    end

    // Frame-level state, stable count and the registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            stable     <= '0;
            prev_h     <= '0;
            prev_v     <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            stable     <= stable_nxt;
            meas_valid <= (state_nxt == VALID);
            locked     <= (state_nxt == VALID) && (stable_nxt == STABLE_MAX);
            if (clear) begin
                prev_h <= '0;
                prev_v <= '0;
            end else if (v_rise && state != IDLE) begin
                prev_h <= h_new;
                prev_v <= l_cnt;
            end
        end
    end

    // Next-state: arm on first frame edge, validate on the second, then track stability
    always_comb begin
        state_nxt  = state;
        stable_nxt = stable;
        case (state)
            IDLE: begin
                if (v_rise)
                    state_nxt = ARM;
            end
            ARM: begin
                if (v_rise) begin
                    state_nxt  = VALID;
                    stable_nxt = '0;
                end
            end
            VALID: begin
                if (v_rise) begin
                    if (!pair_match)
                        stable_nxt = '0;
                    else if (stable != STABLE_MAX)
                        stable_nxt = stable + 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                stable_nxt = '0;
            end
        endcase
        if (ovf || clear) begin
            state_nxt  = IDLE;
            stable_nxt = '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed stimulus for an active-low instance (long
// lines) and an active-high instance (short lines) fed from one sync stream.
module tb_vga_sync_monitor;

    logic clk = 1'b0;
    logic rst_n, clear;
    logic hs_a, vs_a;       // logical "active" sync levels

    logic [11:0] h_total_n, h_sync_len_n, h_total_p, h_sync_len_p;
    logic [10:0] v_total_n, v_sync_len_n, v_total_p, v_sync_len_p;
    logic meas_n, locked_n, fp_n, err_n;
    logic meas_p, locked_p, fp_p, err_p;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int fp_at = 0;
    int t3    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_sync_monitor dut_n (
        .clk(clk), .rst_n(rst_n), .hsync_in(~hs_a), .vsync_in(~vs_a), .clear(clear),
        .h_total(h_total_n), .h_sync_len(h_sync_len_n), .v_total(v_total_n),
        .v_sync_len(v_sync_len_n), .meas_valid(meas_n), .locked(locked_n),
        .frame_pulse(fp_n), .err_overflow(err_n)
    );

    vga_sync_monitor #(.H_POL(1'b1), .V_POL(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n), .hsync_in(hs_a), .vsync_in(vs_a), .clear(clear),
        .h_total(h_total_p), .h_sync_len(h_sync_len_p), .v_total(v_total_p),
        .v_sync_len(v_sync_len_p), .meas_valid(meas_p), .locked(locked_p),
        .frame_pulse(fp_p), .err_overflow(err_p)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame per iteration; every frame starts with hsync and vsync going active together
    task automatic gen(input int htot, input int hlen, input int lines, input int vlen, input int frames);
        for (int f = 0; f < frames; f++)
            for (int l = 0; l < lines; l++)
                for (int c = 0; c < htot; c++) begin
                    @(negedge clk);
                    hs_a = (c < hlen);
                    if (c == 0) vs_a = (l < vlen);
                end
    endtask

    task automatic wait_fp(input bit sel, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            seen = sel ? fp_p : fp_n;
        end
        check_val("fp_seen", seen, 1);
        fp_at = cyc;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; hs_a = 1'b0; vs_a = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_h_total", h_total_p, 0);
        check_val("rst_v_total", v_total_p, 0);
        check_val("rst_meas", meas_p, 0);
        check_val("rst_locked", locked_n, 0);
        check_val("rst_fp", fp_n, 0);
        check_val("rst_err", err_p, 0);
        rst_n = 1'b1;

        // Active-low instance, 800 clk lines with 96 clk hsync, 10-line frames
        fork gen(800, 96, 10, 2, 4); join_none
        wait_fp(0, 9000);
        check_val("a_fp1_meas", meas_n, 0);
        wait_fp(0, 9000);
        check_val("a_fp2_meas", meas_n, 1);
        check_val("a_h_total", h_total_n, 800);
        check_val("a_h_sync_len", h_sync_len_n, 96);
        check_val("a_v_total", v_total_n, 10);
        check_val("a_v_sync_len", v_sync_len_n, 2);
        check_val("a_fp2_locked", locked_n, 0);
        wait_fp(0, 9000);
        check_val("a_fp3_locked", locked_n, 0);
        wait_fp(0, 9000);
        check_val("a_fp4_locked", locked_n, 1);
        wait fork;

        // Active-high instance: 40/6/12/2, reset mid-line, then a 13-line frame
        fork
            begin
                gen(40, 6, 12, 2, 5);
                gen(40, 6, 13, 2, 1);
                gen(40, 6, 12, 2, 4);
            end
        join_none
        repeat (100) @(negedge clk);
        check_val("pre_rst_h_total", h_total_p, 40);
        rst_n = 1'b0;
        #1;
        check_val("arst_h_total", h_total_p, 0);
        check_val("arst_h_sync_len", h_sync_len_p, 0);
        check_val("arst_meas", meas_p, 0);
        check_val("arst_locked", locked_p, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fp(1, 600);
        check_val("b_fp1_meas", meas_p, 0);
        wait_fp(1, 600);
        check_val("b_fp2_meas", meas_p, 1);
        check_val("b_h_total", h_total_p, 40);
        check_val("b_h_sync_len", h_sync_len_p, 6);
        check_val("b_v_total", v_total_p, 12);
        check_val("b_v_sync_len", v_sync_len_p, 2);
        wait_fp(1, 600);
        check_val("b_fp3_locked", locked_p, 0);
        t3 = fp_at;
        @(negedge clk);
        check_val("b_fp_width", fp_p, 0);
        wait_fp(1, 600);
        check_val("b_fp4_locked", locked_p, 1);
        check_val("b_fp_spacing", fp_at - t3, 480);
        wait_fp(1, 600);
        check_val("c_pre_locked", locked_p, 1);
        wait_fp(1, 600);
        check_val("c_v_total13", v_total_p, 13);
        check_val("c_lost_locked", locked_p, 0);
        wait_fp(1, 600);
        check_val("c_back12", v_total_p, 12);
        check_val("c_relock1", locked_p, 0);
        wait_fp(1, 600);
        check_val("c_relock2", locked_p, 0);
        wait_fp(1, 600);
        check_val("c_relock3", locked_p, 1);
        wait fork;

        // hsync stalls long enough to saturate the line-length counter
        repeat (4200) @(negedge clk);
        check_val("stall_err", err_p, 1);
        check_val("stall_meas", meas_p, 0);
        check_val("stall_locked", locked_p, 0);
        fork gen(40, 6, 12, 2, 2); join_none
        wait_fp(1, 600);
        check_val("resume1_meas", meas_p, 0);
        check_val("resume1_err", err_p, 1);
        wait_fp(1, 600);
        check_val("resume2_meas", meas_p, 1);
        check_val("resume2_err", err_p, 1);
        wait fork;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check_val("clr_err", err_p, 0);
        check_val("clr_meas", meas_p, 0);
        check_val("clr_h_total", h_total_p, 0);
        check_val("clr_v_total", v_total_p, 0);
        check_val("clr_h_sync_len", h_sync_len_p, 0);

        // clear lands exactly on the internal vsync edge of the third frame
        fork gen(40, 6, 12, 2, 4); join_none
        wait_fp(1, 600);
        wait_fp(1, 600);
        check_val("coll_pre_meas", meas_p, 1);
        check_val("coll_pre_v_total", v_total_p, 12);
        repeat (479) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_val("coll_fp", fp_p, 0);
        check_val("coll_v_total", v_total_p, 0);
        check_val("coll_meas", meas_p, 0);
        wait_fp(1, 600);
        check_val("coll_idle_meas", meas_p, 0);
        wait fork;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
